// File: rtl/vec_element_sequencer.sv
// Element-serial vector sequencer: walks vl elements through read, PE execute and
// write-back, one element every three cycles, then pulses done.
module vec_element_sequencer #(
    parameter int VLMAX = 8,
    parameter int XLEN  = 64,
    localparam int IW   = $clog2(VLMAX),
    localparam int AW   = 5 + IW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [5:0]      req_funct6,
    input  logic [4:0]      req_vs1,
    input  logic [4:0]      req_vs2,
    input  logic [4:0]      req_vd,
    input  logic [3:0]      req_vl,
    output logic [AW-1:0]   rd_addr_a,
    output logic [AW-1:0]   rd_addr_b,
    input  logic [XLEN-1:0] rd_data_a,
    input  logic [XLEN-1:0] rd_data_b,
    output logic [XLEN-1:0] pe_a,
    output logic [XLEN-1:0] pe_b,
    output logic [5:0]      pe_funct6,
    input  logic [XLEN-1:0] pe_result,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [XLEN-1:0] wr_data,
    output logic            busy,
    output logic            done
);

    // state | meaning
    // IDLE  | ready for a request
    // RD    | drive read addresses for element idx
    // EX    | read data to PE, capture result
    // WB    | write result of element idx
    // FIN   | one-cycle done pulse
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        EX   = 3'd2,
        WB   = 3'd3,
        FIN  = 3'd4
    } state_t;

    localparam int VW = IW + 1;

    state_t          state_q;
    state_t          state_d;
    logic [5:0]      funct6_q;
    logic [4:0]      vs1_q;
    logic [4:0]      vs2_q;
    logic [4:0]      vd_q;
    logic [VW-1:0]   vl_q;
    logic [IW-1:0]   idx_q;
    logic [XLEN-1:0] wdata_q;

    logic            accept;
    logic            last_elem;
    logic [31:0]     req_vl_w;
    logic [31:0]     vl_clamp_w;
    logic [VW-1:0]   vl_eff;

    assign accept     = req_valid && (state_q == IDLE);
    assign req_vl_w   = 32'(req_vl);
    assign vl_clamp_w = (req_vl_w > $unsigned(VLMAX)) ? $unsigned(VLMAX) : req_vl_w;
    assign vl_eff     = vl_clamp_w[VW-1:0];
    assign last_elem  = ({1'b0, idx_q} == (vl_q - VW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (vl_eff == '0) ? FIN : RD;
                end
            end
            RD:      state_d = EX;
            EX:      state_d = WB;
            WB:      state_d = last_elem ? FIN : RD;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operation fields, element index and the registered PE result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct6_q <= '0;
            vs1_q    <= '0;
            vs2_q    <= '0;
            vd_q     <= '0;
            vl_q     <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
        end else begin
            if (accept) begin
                funct6_q <= req_funct6;
                vs1_q    <= req_vs1;
                vs2_q    <= req_vs2;
                vd_q     <= req_vd;
                vl_q     <= vl_eff;
                idx_q    <= '0;
            end
            if (state_q == EX) begin
                wdata_q <= pe_result;
            end
            if ((state_q == WB) && !last_elem) begin
                idx_q <= idx_q + IW'(1);
            end
        end
    end

    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        pe_a      = '0;
        pe_b      = '0;
        pe_funct6 = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        case (state_q)
            IDLE: req_ready = 1'b1;
            RD: begin
                busy      = 1'b1;
                rd_addr_a = {vs1_q, idx_q};
                rd_addr_b = {vs2_q, idx_q};
            end
            EX: begin
                busy      = 1'b1;
                pe_a      = rd_data_a;
                pe_b      = rd_data_b;
                pe_funct6 = funct6_q;
            end
            WB: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = {vd_q, idx_q};
                wr_data = wdata_q;
            end
            FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vec_element_sequencer.sv
// Bench for vec_element_sequencer: register-file and PE models around the DUT,
// directed scenarios plus random ops checked against an element-level reference.
module tb_vec_element_sequencer;

    localparam int VLMAX = 8;
    localparam int XLEN  = 64;
    localparam int IW    = 3;
    localparam int AW    = 5 + IW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [5:0]      req_funct6 = '0;
    logic [4:0]      req_vs1 = '0;
    logic [4:0]      req_vs2 = '0;
    logic [4:0]      req_vd = '0;
    logic [3:0]      req_vl = '0;
    logic [AW-1:0]   rd_addr_a;
    logic [AW-1:0]   rd_addr_b;
    logic [XLEN-1:0] rd_data_a = '0;
    logic [XLEN-1:0] rd_data_b = '0;
    logic [XLEN-1:0] pe_a;
    logic [XLEN-1:0] pe_b;
    logic [5:0]      pe_funct6;
    logic [XLEN-1:0] pe_result;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            busy;
    logic            done;

    vec_element_sequencer #(.VLMAX(VLMAX), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct6(req_funct6), .req_vs1(req_vs1), .req_vs2(req_vs2),
        .req_vd(req_vd), .req_vl(req_vl),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .pe_a(pe_a), .pe_b(pe_b), .pe_funct6(pe_funct6), .pe_result(pe_result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
    } wr_t;

    logic [XLEN-1:0] rf     [32][VLMAX];
    logic [XLEN-1:0] ref_rf [32][VLMAX];
    wr_t wr_log[$];
    wr_t exp_q[$];
    int  done_cnt = 0;
    int  total = 0;
    int  bad = 0;

    function automatic logic [XLEN-1:0] pe_fn(input logic [5:0] f,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        case (f)
            6'b000000: return a + b;
            6'b000010: return a - b;
            default:   return '0;
        endcase
    endfunction

    assign pe_result = pe_fn(pe_funct6, pe_a, pe_b);

    // Register file: synchronous read (data one cycle after address), write on wr_en.
    always @(posedge clk) begin
        rd_data_a <= rf[rd_addr_a[AW-1:IW]][rd_addr_a[IW-1:0]];
        rd_data_b <= rf[rd_addr_b[AW-1:IW]][rd_addr_b[IW-1:0]];
        if (wr_en) rf[wr_addr[AW-1:IW]][wr_addr[IW-1:0]] <= wr_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en) wr_log.push_back('{a: wr_addr, d: wr_data});
        if (done) done_cnt++;
        if (rst_n) check("ready_vs_busy", req_ready, !busy);
    end

    // Reference: every element reads the source values as they stood before the op.
    function automatic int model_op(input logic [5:0] f, input logic [4:0] s1,
                                    input logic [4:0] s2, input logic [4:0] d,
                                    input int vl);
        int vle;
        logic [XLEN-1:0] a_s [VLMAX];
        logic [XLEN-1:0] b_s [VLMAX];
        logic [XLEN-1:0] r;
        vle = (vl > VLMAX) ? VLMAX : vl;
        for (int i = 0; i < VLMAX; i++) begin
            a_s[i] = ref_rf[s1][i];
            b_s[i] = ref_rf[s2][i];
        end
        for (int i = 0; i < vle; i++) begin
            r = pe_fn(f, a_s[i], b_s[i]);
            ref_rf[d][i] = r;
            exp_q.push_back('{a: {d, 3'(i)}, d: r});
        end
        return vle;
    endfunction

    task automatic compare_log(input string tag);
        check({tag, "_nwr"}, wr_log.size(), exp_q.size());
        for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++) begin
            check({tag, "_waddr"}, wr_log[i].a, exp_q[i].a);
            check({tag, "_wdata"}, wr_log[i].d, exp_q[i].d);
        end
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [4:0] d, input logic [3:0] vl);
        int vle;
        int n;
        wr_log.delete();
        exp_q.delete();
        vle = model_op(f, s1, s2, d, int'(vl));
        @(negedge clk);
        check({tag, "_ready"}, req_ready, 1'b1);
        req_funct6 = f; req_vs1 = s1; req_vs2 = s2; req_vd = d; req_vl = vl;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        if (vle > 0) begin
            check({tag, "_rd_addr_a"}, rd_addr_a, {s1, 3'd0});
            check({tag, "_rd_addr_b"}, rd_addr_b, {s2, 3'd0});
            check({tag, "_pe_f_rd"}, pe_funct6, 6'd0);
            @(negedge clk);
            check({tag, "_pe_f_ex"}, pe_funct6, f);
            check({tag, "_wr_en_ex"}, wr_en, 1'b0);
            wait_done(n);
            n++;
        end else begin
            wait_done(n);
        end
        check({tag, "_latency"}, n, 3 * vle + 1);
        compare_log(tag);
        @(negedge clk);
        check({tag, "_done_1cyc"}, done, 1'b0);
        check({tag, "_ready_after"}, req_ready, 1'b1);
    endtask

    initial begin
        logic [XLEN-1:0] v;
        int n;
        int nmis;
        int dc;
        logic [5:0] f;
        for (int r = 0; r < 32; r++) begin
            for (int i = 0; i < VLMAX; i++) begin
                v = {$urandom, $urandom};
                rf[r][i] = v;
                ref_rf[r][i] = v;
            end
        end
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_rd_addr", {rd_addr_a, rd_addr_b, wr_addr}, '0);
        check("rst_wr_data", wr_data, '0);
        check("rst_pe", pe_a | pe_b | 64'(pe_funct6), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // VADD
        for (int i = 0; i < VLMAX; i++) begin
            rf[1][i] = 64'(i + 1); ref_rf[1][i] = 64'(i + 1);
            rf[2][i] = 64'd10;     ref_rf[2][i] = 64'd10;
        end
        run_op("vadd", 6'b000000, 5'd1, 5'd2, 5'd3, 4'd4);
        for (int i = 0; i < 4; i++) check("vadd_v3", rf[3][i], 64'(11 + i));

        run_op("vl0", 6'b000101, 5'd7, 5'd8, 5'd9, 4'd0);
        run_op("clamp", 6'b000000, 5'd10, 5'd11, 5'd12, 4'd15);

        // in-place VSUB
        for (int i = 0; i < VLMAX; i++) begin
            rf[5][i] = 64'd100; ref_rf[5][i] = 64'd100;
            rf[6][i] = 64'(i);  ref_rf[6][i] = 64'(i);
        end
        run_op("vsub", 6'b000010, 5'd5, 5'd6, 5'd5, 4'd8);
        for (int i = 0; i < VLMAX; i++) check("vsub_v5", rf[5][i], 64'(100 - i));

        // back-to-back with req_valid held high
        wr_log.delete();
        exp_q.delete();
        void'(model_op(6'b000000, 5'd1, 5'd2, 5'd20, 3));
        void'(model_op(6'b000010, 5'd20, 5'd3, 5'd21, 2));
        @(negedge clk);
        req_funct6 = 6'b000000; req_vs1 = 5'd1; req_vs2 = 5'd2; req_vd = 5'd20; req_vl = 4'd3;
        req_valid = 1'b1;
        @(negedge clk);
        check("b2b_busy1", busy, 1'b1);
        req_funct6 = 6'b000010; req_vs1 = 5'd20; req_vs2 = 5'd3; req_vd = 5'd21; req_vl = 4'd2;
        wait_done(n);
        check("b2b_lat1", n, 10);
        check("b2b_nwr_at_done1", wr_log.size(), 3);
        @(negedge clk);
        check("b2b_ready_gap", req_ready, 1'b1);
        @(negedge clk);
        check("b2b_busy2", busy, 1'b1);
        req_valid = 1'b0;
        wait_done(n);
        check("b2b_lat2", n, 7);
        compare_log("b2b");
        @(negedge clk);

        // reset during EX of element 2
        wr_log.delete();
        exp_q.delete();
        void'(model_op(6'b000000, 5'd13, 5'd14, 5'd15, 2));
        req_funct6 = 6'b000000; req_vs1 = 5'd13; req_vs2 = 5'd14; req_vd = 5'd15; req_vl = 4'd8;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_ex_funct", pe_funct6 | 6'd1, 6'd1);
        dc = done_cnt;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", req_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_wr_en", wr_en, 1'b0);
        check("mid_rst_addr", {rd_addr_a, rd_addr_b, wr_addr}, '0);
        check("mid_rst_data", wr_data | pe_a | pe_b | 64'(pe_funct6), '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_no_done", done_cnt, dc);
        check("mid_idle", req_ready, 1'b1);
        compare_log("mid");

        // random ops
        for (int k = 0; k < 25; k++) begin
            case ($urandom_range(0, 3))
                0: f = 6'b000000;
                1: f = 6'b000010;
                default: f = 6'($urandom);
            endcase
            run_op("rnd", f, 5'($urandom), 5'($urandom), 5'($urandom), 4'($urandom_range(0, 15)));
        end

        nmis = 0;
        for (int r = 0; r < 32; r++)
            for (int i = 0; i < VLMAX; i++)
                if (rf[r][i] !== ref_rf[r][i]) nmis++;
        check("rf_final", nmis, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vec_element_sequencer.md
VEC_ELEMENT_SEQUENCER -- requirements
Module: vec_element_sequencer

Interface
REQ-001 The block SHALL have parameter VLMAX, default 8: maximum elements per vector register (power of two).
REQ-002 The block SHALL have parameter XLEN, default 64: element width in bits.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  vector op request
- req_ready  out  1  sequencer can accept a request
- req_funct6  in  6  operation code, passed to the PE
- req_vs1, req_vs2, req_vd  in  5 each  source A, source B and destination vector register
- req_vl  in  4  element count
- rd_addr_a, rd_addr_b  out  5+log2(VLMAX)  register-file read address {vreg, elem}
- rd_data_a, rd_data_b  in  XLEN  read data, one cycle after the address
- pe_a, pe_b  out  XLEN  PE operands
- pe_funct6  out  6  PE operation code
- pe_result  in  XLEN  combinational PE result
- wr_en  out  1  register-file write strobe
- wr_addr  out  5+log2(VLMAX)  write address {vd, elem}
- wr_data  out  XLEN  write data
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse

Function
REQ-005 The FSM SHALL have the states IDLE, RD, EX, WB and FIN.
REQ-006 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-007 A request SHALL be accepted when req_valid & req_ready.
- On acceptance, the block SHALL latch funct6, vs1, vs2, vd and the effective vl.
- The element index SHALL clear to 0.
REQ-008 Effective vl SHALL equal min(req_vl, VLMAX).
REQ-009 After acceptance with effective vl = 0, the FSM SHALL go IDLE -> FIN, with no reads driven and no writes.
REQ-010 After acceptance with effective vl > 0, the FSM SHALL go IDLE -> RD.
REQ-011 In RD, rd_addr_a SHALL be {vs1, idx} and rd_addr_b SHALL be {vs2, idx}.
- Next state: EX.
REQ-012 In EX, pe_a SHALL equal rd_data_a, pe_b SHALL equal rd_data_b, and pe_funct6 SHALL equal the latched funct6.
- pe_result SHALL be registered into the write-data register.
- Next state: WB.
REQ-013 In WB, wr_en SHALL be 1, wr_addr SHALL be {vd, idx}, and wr_data SHALL be the registered result.
- If idx = vl-1, the next state SHALL be FIN.
- Otherwise idx SHALL increment and the next state SHALL be RD.
REQ-014 In FIN, done SHALL be 1 for exactly one cycle.
- Next state: IDLE.
REQ-015 busy SHALL be 1 in the states RD, EX, WB and FIN, and 0 in IDLE.
REQ-016 wr_en SHALL be 0 in every state other than WB.
- Exactly vl writes SHALL occur per operation, in ascending element order.
REQ-017 pe_a, pe_b and pe_funct6 SHALL be driven to 0 outside EX.
REQ-018 Per-op latency from acceptance to done SHALL be 3*vl + 1 cycles.
- For vl = 0, done SHALL assert in the cycle after acceptance.
REQ-019 Element index arithmetic SHALL be log2(VLMAX) bits wide.
- idx SHALL never exceed vl-1, so no wrap-around occurs.
REQ-020 Overlap of vd with vs1 or vs2 SHALL be legal.
- Element i is always read before it is written.
- Element i is never re-read after its write.
REQ-021 funct6 SHALL be passed through unmodified, whether or not the PE supports it.
- The PE's result for unsupported codes, 0, SHALL be written normally.
REQ-022 req_valid held high during a busy period SHALL be ignored.
- The request SHALL be accepted on the first IDLE cycle afterwards, which is the cycle after FIN.

Reset
REQ-023 While rst_n = 0, the block SHALL be in IDLE, with:
- req_ready = 1
- busy = 0, done = 0, wr_en = 0
- all address, data and PE outputs = 0
- latched fields and idx = 0
REQ-024 Reset asserted mid-operation SHALL abort the operation immediately.
- No further write SHALL occur.
- done SHALL not pulse.
- After release, the block SHALL wait in IDLE for a new request.

Verification
REQ-025 The bench SHALL cover VADD:
- Stimulus: funct6=000000, vs1=1, vs2=2, vd=3, vl=4; v1[i]=i+1, v2[i]=10.
- Response: writes v3[0..3] = 11, 12, 13, 14 at addresses {3,0}..{3,3}.
- done SHALL pulse 13 cycles after acceptance.
REQ-026 The bench SHALL cover vl=0:
- Stimulus: any op with vl=0.
- Response: no wr_en; done one cycle after acceptance; req_ready back to 1 the cycle after done.
REQ-027 The bench SHALL cover the vl clamp:
- Stimulus: vl=15 with VLMAX=8.
- Response: exactly 8 writes, elements 0..7; done at 25 cycles.
REQ-028 The bench SHALL cover in-place VSUB:
- Stimulus: funct6=000010, vs1=vd=5, vs2=6; v5[i]=100, v6[i]=i; vl=8.
- Response: v5[i] = 100-i for all i.
REQ-029 The bench SHALL cover back-to-back requests:
- Stimulus: req_valid held high with two queued ops.
- Response: the second op is accepted the cycle after the first done; no write overlap.
REQ-030 The bench SHALL cover reset mid-operation:
- Stimulus: rst_n low during EX of element 2 of a vl=8 op.
- Response: outputs take REQ-023 values; only elements 0..1 were written; no done pulse.
